// File: rtl/keccak_byte_packer.sv
// keccak_byte_packer
//   Packs a byte stream into 64-bit big-endian words for a Keccak core.
//   The first byte of a word lands in [63:56]. A message that ends exactly
//   on a word boundary is followed by one all-zero pad word with is_last=1
//   and byte_num=0.
//   Optional feature: define KECCAK_PACKER_LEN_EN to add the msg_len output,
//   a 32-bit wrapping count of accepted bytes.
module keccak_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [63:0] in,
  output logic        in_ready,
  output logic        is_last,
  output logic [2:0]  byte_num,
  input  logic        ack,
`ifdef KECCAK_PACKER_LEN_EN
  output logic        done,
  output logic [31:0] msg_len
`else
  output logic        done
`endif
);

  typedef enum logic [1:0] {
    ACCUM    = 2'd0,
    SEND     = 2'd1,
    SEND_PAD = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [2:0]  cnt;          // byte position inside the current word
  logic [63:0] word;         // word under construction / being offered
  logic        pad_pending;  // message ended on byte 7: a zero pad word follows
  logic        last_q;       // the word being offered is the final one
  logic [2:0]  num_q;        // valid byte count of the final word

  logic        byte_xfer;
  logic        word_xfer;
  logic        word_done;    // this byte completes the word in progress
  logic [5:0]  byte_lsb;     // bit offset of byte slot cnt, i.e. 8*(7-cnt)

  assign byte_xfer = s_valid && s_ready;
  assign word_xfer = ack && in_ready;
  assign word_done = s_last || (cnt == 3'd7);
  // 7-cnt equals ~cnt for a 3-bit counter.
  assign byte_lsb  = {~cnt, 3'b000};

  // State register; reset is asynchronous so in_ready drops without a clock.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!reset) begin
      state <= ACCUM;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and all handshake/word outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned, which would infer a latch.
    next_state = state;
    s_ready    = 1'b0;
    in_ready   = 1'b0;
    done       = 1'b0;
    in         = word;
    is_last    = 1'b0;
    byte_num   = 3'd0;
    unique case (state)
      ACCUM: begin
        s_ready = 1'b1;
        if (s_valid && word_done) begin
          next_state = SEND;
        end
      end
      SEND: begin
        in_ready = 1'b1;
        is_last  = last_q;
        byte_num = num_q;
        if (ack) begin
          if (last_q) begin
            next_state = DONE;
          end else if (pad_pending) begin
            next_state = SEND_PAD;
          end else begin
            next_state = ACCUM;
          end
        end
      end
      SEND_PAD: begin
        in_ready = 1'b1;
        in       = 64'd0;
        is_last  = 1'b1;
        byte_num = 3'd0;
        if (ack) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        next_state = ACCUM;
      end
    endcase
  end

  // Word assembly, position counter and end-of-message bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word        <= 64'd0;
      cnt         <= 3'd0;
      pad_pending <= 1'b0;
      last_q      <= 1'b0;
      num_q       <= 3'd0;
    end else if (byte_xfer) begin
      word[byte_lsb +: 8] <= s_data;
      if (s_last) begin
        if (cnt == 3'd7) begin
          // Full final word: offer it as non-final, then the zero pad word.
          pad_pending <= 1'b1;
          last_q      <= 1'b0;
          num_q       <= 3'd0;
        end else begin
          // Unused bytes are already zero because the word starts cleared.
          last_q <= 1'b1;
          num_q  <= cnt + 3'd1;
        end
      end else if (cnt != 3'd7) begin
        cnt <= cnt + 3'd1;
      end
    end else if (word_xfer && (state == SEND) && !last_q && !pad_pending) begin
      // Mid-message word consumed: start the next word from a clean slate.
      word <= 64'd0;
      cnt  <= 3'd0;
    end
  end

`ifdef KECCAK_PACKER_LEN_EN
  // Accepted-byte counter; byte transfers only happen in ACCUM, so it
  // freezes naturally once the message is done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_len <= 32'd0;
    end else if (byte_xfer) begin
      msg_len <= msg_len + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_keccak_byte_packer.sv
// tb_keccak_byte_packer
//   Directed bench for keccak_byte_packer. Inputs change 1 ns after the
//   rising edge and outputs are sampled there too, away from the edge.
//   Define KECCAK_PACKER_LEN_EN to also check msg_len.
module tb_keccak_byte_packer;

  logic        clk;
  logic        reset;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [63:0] in;
  logic        in_ready;
  logic        is_last;
  logic [2:0]  byte_num;
  logic        ack;
  logic        done;
`ifdef KECCAK_PACKER_LEN_EN
  logic [31:0] msg_len;
`endif

  int checks = 0;
  int errors = 0;

  keccak_byte_packer dut (
    .clk      (clk),
    .reset    (reset),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .in       (in),
    .in_ready (in_ready),
    .is_last  (is_last),
    .byte_num (byte_num),
    .ack      (ack),
`ifdef KECCAK_PACKER_LEN_EN
    .done     (done),
    .msg_len  (msg_len)
`else
    .done     (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until it is accepted (bounded wait).
  task automatic put(input logic [7:0] d, input logic l);
    int waited;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    waited  = 0;
    while (!s_ready && waited < 20) begin
      tick();
      waited++;
    end
    check("put_ready", {63'd0, s_ready}, 64'd1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
  endtask

  // Assert reset between edges, check the reset state, release after an edge.
  task automatic do_reset();
    #3;
    reset = 1'b0;
    #1;
    check("rst_s_ready",  {63'd0, s_ready},  64'd1);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_done",     {63'd0, done},     64'd0);
    check("rst_is_last",  {63'd0, is_last},  64'd0);
    check("rst_byte_num", {61'd0, byte_num}, 64'd0);
    check("rst_in",       in,                64'd0);
`ifdef KECCAK_PACKER_LEN_EN
    check("rst_msg_len",  {32'd0, msg_len},  64'd0);
`endif
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset   = 1'b0;
    s_data  = 8'h00;
    s_valid = 1'b0;
    s_last  = 1'b0;
    ack     = 1'b0;
    tick();
    do_reset();

    // 3-byte message, ack held high throughout (ack ignored while not offering).
    ack = 1'b1;
    put(8'h01, 1'b0);
    put(8'h02, 1'b0);
    put(8'h03, 1'b1);
    check("m3_in_ready", {63'd0, in_ready}, 64'd1);
    check("m3_s_ready",  {63'd0, s_ready},  64'd0);
    check("m3_in",       in,                64'h0102030000000000);
    check("m3_is_last",  {63'd0, is_last},  64'd1);
    check("m3_byte_num", {61'd0, byte_num}, 64'd3);
    tick();
    check("m3_done",     {63'd0, done},     64'd1);
    check("m3_in_ready_low", {63'd0, in_ready}, 64'd0);
    check("m3_is_last_low",  {63'd0, is_last},  64'd0);
`ifdef KECCAK_PACKER_LEN_EN
    check("m3_msg_len",  {32'd0, msg_len},  64'd3);
`endif

    // DONE is terminal: source activity is ignored.
    s_valid = 1'b1;
    s_data  = 8'hEE;
    s_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("done_s_ready",  {63'd0, s_ready},  64'd0);
      check("done_in_ready", {63'd0, in_ready}, 64'd0);
      check("done_done",     {63'd0, done},     64'd1);
      tick();
    end
`ifdef KECCAK_PACKER_LEN_EN
    check("done_msg_len_frozen", {32'd0, msg_len}, 64'd3);
`endif
    s_valid = 1'b0;
    s_last  = 1'b0;

    // 8-byte message: full word then a zero pad word.
    do_reset();
    ack = 1'b1;
    for (int i = 0; i < 8; i++) put(8'(i), (i == 7));
    check("m8_w0_in",       in,                64'h0001020304050607);
    check("m8_w0_in_ready", {63'd0, in_ready}, 64'd1);
    check("m8_w0_is_last",  {63'd0, is_last},  64'd0);
    tick();
    check("m8_pad_in",       in,                64'd0);
    check("m8_pad_in_ready", {63'd0, in_ready}, 64'd1);
    check("m8_pad_is_last",  {63'd0, is_last},  64'd1);
    check("m8_pad_byte_num", {61'd0, byte_num}, 64'd0);
    check("m8_pad_s_ready",  {63'd0, s_ready},  64'd0);
    tick();
    check("m8_done", {63'd0, done}, 64'd1);

    // 12-byte message with the core stalling for 5 cycles.
    do_reset();
    ack = 1'b0;
    for (int i = 0; i < 8; i++) put(8'h10 + 8'(i), 1'b0);
    s_valid = 1'b1;
    s_data  = 8'h18;
    for (int i = 0; i < 5; i++) begin
      check("stall_in",       in,                64'h1011121314151617);
      check("stall_in_ready", {63'd0, in_ready}, 64'd1);
      check("stall_s_ready",  {63'd0, s_ready},  64'd0);
      check("stall_is_last",  {63'd0, is_last},  64'd0);
      tick();
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("resume_s_ready",  {63'd0, s_ready},  64'd1);
    check("resume_in_ready", {63'd0, in_ready}, 64'd0);
    put(8'h18, 1'b0);
    put(8'h19, 1'b0);
    put(8'h1A, 1'b0);
    put(8'h1B, 1'b1);
    check("m12_in",       in,                64'h18191A1B00000000);
    check("m12_is_last",  {63'd0, is_last},  64'd1);
    check("m12_byte_num", {61'd0, byte_num}, 64'd4);
    ack = 1'b1;
    tick();
    check("m12_done", {63'd0, done}, 64'd1);

    // Reset while a full word is offered: in_ready falls without a clock.
    do_reset();
    ack = 1'b0;
    for (int i = 0; i < 8; i++) put(8'hC0 + 8'(i), 1'b0);
    check("mid_in_ready_pre", {63'd0, in_ready}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_in_ready_async", {63'd0, in_ready}, 64'd0);
    check("mid_s_ready_async",  {63'd0, s_ready},  64'd1);
    check("mid_in_async",       in,                64'd0);
    tick();
    reset = 1'b1;

    // Abandon a 5-byte partial message with reset, then send 2 bytes.
    for (int i = 0; i < 5; i++) put(8'hA0 + 8'(i), 1'b0);
    do_reset();
    put(8'h55, 1'b0);
    put(8'h66, 1'b1);
    check("m2_in",       in,                64'h5566000000000000);
    check("m2_is_last",  {63'd0, is_last},  64'd1);
    check("m2_byte_num", {61'd0, byte_num}, 64'd2);
    ack = 1'b1;
    tick();
    check("m2_done", {63'd0, done}, 64'd1);

    // 17-byte message: two full words then a 1-byte final word.
    do_reset();
    ack = 1'b1;
    for (int i = 1; i <= 8; i++) put(8'(i), 1'b0);
    check("m17_w0_in",      in,               64'h0102030405060708);
    check("m17_w0_is_last", {63'd0, is_last}, 64'd0);
    tick();
    for (int i = 9; i <= 16; i++) put(8'(i), 1'b0);
    check("m17_w1_in",      in,               64'h090A0B0C0D0E0F10);
    check("m17_w1_is_last", {63'd0, is_last}, 64'd0);
    tick();
    put(8'h11, 1'b1);
    check("m17_w2_in",       in,                64'h1100000000000000);
    check("m17_w2_is_last",  {63'd0, is_last},  64'd1);
    check("m17_w2_byte_num", {61'd0, byte_num}, 64'd1);
    tick();
    check("m17_done", {63'd0, done}, 64'd1);
`ifdef KECCAK_PACKER_LEN_EN
    check("m17_msg_len", {32'd0, msg_len}, 64'd17);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keccak_byte_packer.md
KECCAK_BYTE_PACKER -- requirements
Module: keccak_byte_packer

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, reset. reset SHALL be asynchronous and active-low.
REQ-002 Port list, in order:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- s_data  input  8  message byte from the source.
- s_valid  input  1  s_data is valid.
- s_last  input  1  the current byte is the final message byte.
- s_ready  output  1  the block accepts a byte this cycle.
- in  output  64  packed word to the hash core; first byte of the word in [63:56].
- in_ready  output  1  in, is_last and byte_num are valid.
- is_last  output  1  this word is the final word of the message.
- byte_num  output  3  valid byte count when is_last=1; ignored when is_last=0.
- ack  input  1  the hash core has consumed the current word.
- done  output  1  the final word has been consumed.
REQ-003 No parameters; all widths are fixed.

Function
REQ-004 A byte transfer SHALL occur on a rising edge where s_valid=1 and s_ready=1; a word transfer SHALL occur on a rising edge where in_ready=1 and ack=1.
REQ-005 States: ACCUM, SEND, SEND_PAD, DONE. s_ready=1 only in ACCUM; in_ready=1 only in SEND and SEND_PAD; done=1 only in DONE.
REQ-006 In ACCUM, byte k (k=0..7) of a word SHALL be stored at in[63-8k:56-8k], with k taken from a 3-bit position counter cnt.
REQ-007 In ACCUM, on a byte transfer with s_last=0 and cnt<7, the block SHALL increment cnt and stay in ACCUM.
REQ-008 In ACCUM, on a byte transfer with s_last=0 and cnt=7, the block SHALL go to SEND with is_last=0.
REQ-009 In ACCUM, on a byte transfer with s_last=1 and cnt<7, the block SHALL go to SEND with is_last=1, byte_num=cnt+1, and all unused bytes of in zero.
REQ-010 In ACCUM, on a byte transfer with s_last=1 and cnt=7, the block SHALL go to SEND with is_last=0 and set a pad_pending flag.
REQ-011 In SEND, in, is_last and byte_num SHALL be held stable until a word transfer occurs.
REQ-012 On a word transfer in SEND, the next state SHALL be:
- DONE if is_last=1;
- SEND_PAD if pad_pending=1;
- otherwise ACCUM, with cnt=0 and the word register cleared.
REQ-013 In SEND_PAD, the outputs SHALL be in=0, is_last=1, byte_num=0; on a word transfer the block SHALL go to DONE.
REQ-014 DONE SHALL be terminal until reset: s_ready=0 and in_ready=0, and all s_valid activity is ignored.
REQ-015 Latency: in_ready SHALL rise in the cycle immediately after the edge that completes a word; s_ready SHALL rise in the cycle immediately after the ack edge.
REQ-016 If ack=1 while in_ready=0, the block SHALL ignore it.
REQ-017 Zero-length messages are not supported; every message SHALL contain at least one byte carrying s_last=1.
REQ-018 is_last and byte_num SHALL be 0 whenever in_ready=0.

Reset
REQ-019 While reset=0, the block SHALL be in ACCUM with cnt=0, the word register=0, pad_pending=0, in_ready=0, is_last=0, byte_num=0, done=0 and s_ready=1.
REQ-020 Reset asserted mid-message or mid-handshake SHALL clear all state immediately, without waiting for clk, and discard partial data; in_ready SHALL fall asynchronously.

Configuration
REQ-021 Macro KECCAK_PACKER_LEN_EN.
- When defined: an extra output port msg_len [31:0] SHALL count accepted bytes (reset 0, +1 per byte transfer, wrapping at 2^32, frozen in DONE).
- When undefined: the port and its counter SHALL be absent, and all other behaviour is identical.

Verification
REQ-022 Send bytes 0x01..0x03 with s_last on 0x03, ack held 1 -> one word in=0x0102030000000000, is_last=1, byte_num=3; then done=1.
REQ-023 Send bytes 0x00..0x07 with s_last on 0x07, ack held 1 -> word 0x0001020304050607 with is_last=0, then word 0 with is_last=1, byte_num=0; then done=1.
REQ-024 Send a 12-byte message with ack held 0 for 5 cycles after the first in_ready -> in stable and s_ready=0 throughout; the word transfers on the first ack edge and accumulation resumes the next cycle.
REQ-025 Assert reset after 5 bytes of a message, then send a 2-byte message -> the first message is discarded; one word with is_last=1, byte_num=2 carries only the new bytes.
REQ-026 With KECCAK_PACKER_LEN_EN defined, send a 17-byte message -> msg_len=17 in DONE; words sent have is_last=0, is_last=0, then is_last=1 with byte_num=1.
REQ-027 In DONE, drive s_valid=1 for 10 cycles -> s_ready=0, in_ready=0 and done=1 throughout.
